nibble_serial_adder: RTL

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder_pkg.sv | 12 +
 rtl/four_bit_adder.sv | 12 +
 rtl/nibble_serial_adder.sv | 103 ++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding and nibble width.
package nibble_serial_adder_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAdd  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/four_bit_adder.sv
// Plain 4-bit ripple adder with carry in and carry out.
module four_bit_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// Adds two WIDTH-bit operands one nibble per cycle through a single 4-bit adder,
// rippling the carry between cycles via carry_q.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
    localparam int unsigned IDX_W   = $clog2(NIBBLES);

    state_e                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    carry_q;
    logic [WIDTH-1:0]        a_q;
    logic [WIDTH-1:0]        b_q;

    logic [NIBBLE_W-1:0]     nib_a;
    logic [NIBBLE_W-1:0]     nib_b;
    logic [NIBBLE_W-1:0]     nib_sum;
    logic                    nib_cout;
    logic                    last_nib;

    assign nib_a    = a_q[idx_q * NIBBLE_W +: NIBBLE_W];
    assign nib_b    = b_q[idx_q * NIBBLE_W +: NIBBLE_W];
    assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

    four_bit_adder u_adder (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // Handshake flags are registered alongside the state so they change only with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        carry_q  <= cin;
                        idx_q    <= '0;
                        state_q  <= StAdd;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                StAdd: begin
                    sum[idx_q * NIBBLE_W +: NIBBLE_W] <= nib_sum;
                    carry_q <= nib_cout;
                    idx_q   <= idx_q + 1'b1;
                    if (last_nib) begin
                        cout      <= nib_cout;
                        state_q   <= StDone;
                        out_valid <= 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q   <= StIdle;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
